// File: rtl/cgra_config_arbiter_pkg.sv
// Shared types for the CGRA configuration arbiter.
// FSM states and the issue-register bundle.
package cfg_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_RESP
    } arb_state_t;

    // Issue register; fields sized to the widest supported bus.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              read;
        logic              write;
    } cfg_req_t;

endpackage

// File: rtl/cgra_config_arbiter_if.sv
// Requester ports plus interconnect config bus of the arbiter.
// slave = arbiter side, master = requesters and interconnect.
interface cgra_config_arbiter_if #(
    parameter int N_PORTS = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [N_PORTS-1:0]        req_valid;
    logic [N_PORTS-1:0]        req_ready;
    logic [N_PORTS*ADDR_W-1:0] req_addr;
    logic [N_PORTS*DATA_W-1:0] req_data;
    logic [N_PORTS-1:0]        req_read;
    logic [N_PORTS-1:0]        req_write;
    logic [N_PORTS-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [ADDR_W-1:0]         cfg_addr;
    logic [DATA_W-1:0]         cfg_data;
    logic                      cfg_read;
    logic                      cfg_write;
    logic [DATA_W-1:0]         cfg_rd_data;

    modport slave (
        input  req_valid, req_addr, req_data, req_read, req_write,
        input  cfg_rd_data,
        output req_ready, rsp_valid, rsp_data,
        output cfg_addr, cfg_data, cfg_read, cfg_write
    );

    modport master (
        output req_valid, req_addr, req_data, req_read, req_write,
        output cfg_rd_data,
        input  req_ready, rsp_valid, rsp_data,
        input  cfg_addr, cfg_data, cfg_read, cfg_write
    );
endinterface

// File: rtl/cgra_config_arbiter_rr_arbiter.sv
// Round-robin grant with the last-grant pointer held locally.
// Search starts one past the last granted port and wraps.
module rr_arbiter #(
    parameter int N_PORTS = 8,
    parameter int IW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PORTS-1:0] req,
    input  logic               en,
    output logic [N_PORTS-1:0] grant,
    output logic [IW-1:0]      idx
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] j;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            j = IW'((int'(ptr) + k) % N_PORTS);
            if (en && !found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= IW'(N_PORTS - 1);
        end else if (found) begin
            ptr <= idx;
        end
    end

endmodule

// File: rtl/cgra_config_arbiter.sv
// Merges per-slice config requests onto one interconnect config bus.
// Writes issue one per cycle; reads block until the response returns.
module cgra_config_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int N_PORTS  = 8,
    parameter int ADDR_W   = cfg_arb_pkg::ADDR_W,
    parameter int DATA_W   = cfg_arb_pkg::DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    cgra_config_arbiter_if.slave  bus,
    output logic                  err_both
);
    localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CW = 3;

    arb_state_t         state;
    arb_state_t         state_nx;
    logic [N_PORTS-1:0] grant;
    logic [IW-1:0]      gidx;
    logic               acc;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_rd;
    logic               sel_wr;
    cfg_req_t           iss;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      rd_port;
    logic [N_PORTS-1:0] rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;

    rr_arbiter #(.N_PORTS(N_PORTS), .IW(IW)) u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (bus.req_valid),
        .en    (state == IDLE && !reset),
        .grant (grant),
        .idx   (gidx)
    );

    assign acc           = |grant;
    assign bus.req_ready = grant;
    assign sel_rd        = |(grant & bus.req_read);
    assign sel_wr        = |(grant & bus.req_write);

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant[i]) begin
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (acc && sel_rd && !sel_wr) state_nx = RD_WAIT;
            RD_WAIT: if (cnt == '0) state_nx = RD_RESP;
            RD_RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A request carrying both flags issues as a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            iss         <= '0;
            cnt         <= '0;
            rd_port     <= '0;
            err_both    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            iss.read    <= 1'b0;
            iss.write   <= 1'b0;
            rsp_valid_q <= '0;
            if (acc) begin
                iss.addr  <= cfg_arb_pkg::ADDR_W'(sel_addr);
                iss.data  <= cfg_arb_pkg::DATA_W'(sel_data);
                iss.write <= sel_wr;
                iss.read  <= sel_rd & ~sel_wr;
                rd_port   <= gidx;
                if (sel_rd && sel_wr) err_both <= 1'b1;
            end
            if (acc && sel_rd && !sel_wr) begin
                cnt <= CW'(READ_LAT);
            end else if (state == RD_WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (state == RD_WAIT && cnt == '0) begin
                rsp_valid_q[rd_port] <= 1'b1;
                rsp_data_q           <= bus.cfg_rd_data;
            end
        end
    end

    assign bus.cfg_addr  = iss.addr[ADDR_W-1:0];
    assign bus.cfg_data  = iss.data[DATA_W-1:0];
    assign bus.cfg_read  = iss.read;
    assign bus.cfg_write = iss.write;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule
